// File: rtl/fp_mult_seq_ctrl.sv
// Sequencing wrapper for the iterative shift-add FP32 multiplier core: operand handshake,
// core restart, iteration count, result capture. Optional FP_SPECIAL_BYPASS_EN short-cuts specials.
module fp_mult_seq_ctrl #(
  parameter int unsigned MUL_CYCLES = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] mul_A,
  output logic [31:0] mul_B,
  output logic        mul_RST,
  input  logic [31:0] mul_result,
  input  logic        mul_overflow,
  input  logic        mul_underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            mul_rst_q;
  logic            accept;
  logic            run_done;
  logic            byp;
  logic [31:0]     byp_result;
  logic            byp_invalid;

  assign accept   = in_ready & in_valid;
  assign run_done = (state_q == StRun) && (cnt_q == CntW'(MUL_CYCLES));
  assign mul_RST  = mul_rst_q;

`ifdef FP_SPECIAL_BYPASS_EN
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign;

  always_comb begin
    a_zero      = (A_in[30:23] == 8'h00);
    a_inf       = (A_in[30:23] == 8'hFF) && (A_in[22:0] == 23'd0);
    a_nan       = (A_in[30:23] == 8'hFF) && (A_in[22:0] != 23'd0);
    b_zero      = (B_in[30:23] == 8'h00);
    b_inf       = (B_in[30:23] == 8'hFF) && (B_in[22:0] == 23'd0);
    b_nan       = (B_in[30:23] == 8'hFF) && (B_in[22:0] != 23'd0);
    sign        = A_in[31] ^ B_in[31];
    byp         = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    byp_invalid = 1'b0;
    if (a_nan || b_nan) begin
      byp_result = 32'h7FC0_0000;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      byp_result  = 32'h7FC0_0000;
      byp_invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      byp_result = {sign, 8'hFF, 23'd0};
    end else begin
      // Denormals are flushed to zero, so any remaining special is a signed zero.
      byp_result = {sign, 31'd0};
    end
  end
`else
  assign byp         = 1'b0;
  assign byp_result  = 32'd0;
  assign byp_invalid = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = byp ? StDone : StLoad;
      StLoad: state_d = StRun;
      StRun:  if (run_done) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mul_A     <= 32'd0;
      mul_B     <= 32'd0;
      mul_rst_q <= 1'b0;
      cnt_q     <= '0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      if (accept) begin
        mul_A <= A_in;
        mul_B <= B_in;
        if (byp) begin
          result    <= byp_result;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          invalid   <= byp_invalid;
        end else begin
          // Core is pulsed into reset for the LOAD cycle only.
          mul_rst_q <= 1'b0;
        end
      end
      if (state_q == StLoad) begin
        mul_rst_q <= 1'b1;
        cnt_q     <= '0;
      end
      if (state_q == StRun && !run_done) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (run_done) begin
        result    <= mul_result;
        overflow  <= mul_overflow;
        underflow <= mul_underflow;
        invalid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Bench for fp_mult_seq_ctrl: a timed behavioural core stand-in plus a reference model of the
// wrapper's results and latency, driven with directed and random operand pairs.
module tb_fp_mult_seq_ctrl;

  localparam int MulCycles = 24;
  localparam int OpLimit   = 100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready;
  logic [31:0] A_in, B_in, mul_A, mul_B;
  logic        mul_RST;
  logic [31:0] mul_result;
  logic        mul_overflow, mul_underflow;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, invalid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fp_mult_seq_ctrl #(.MUL_CYCLES(MulCycles)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A_in         (A_in),
    .B_in         (B_in),
    .mul_A        (mul_A),
    .mul_B        (mul_B),
    .mul_RST      (mul_RST),
    .mul_result   (mul_result),
    .mul_overflow (mul_overflow),
    .mul_underflow(mul_underflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .overflow     (overflow),
    .underflow    (underflow),
    .invalid      (invalid)
  );

  // Truncating FP32 product of normal operands: {overflow, underflow, result}.
  function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e > 254) return {2'b10, s, 8'hFF, 23'd0};
    if (e < 1) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  // Core stand-in: output is only correct once MulCycles iterations have elapsed since restart.
  int          core_left;
  logic [33:0] core_out;

  always_ff @(posedge CLK) begin
    if (!mul_RST) core_left <= MulCycles;
    else if (core_left > 0) core_left <= core_left - 1;
  end

  always_comb begin
    core_out = core_fn(mul_A, mul_B);
    if (core_left != 0) core_out = ~core_out;
  end

  assign mul_result    = core_out[31:0];
  assign mul_underflow = core_out[32];
  assign mul_overflow  = core_out[33];

  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r,
                           output logic ov, output logic un, output logic inv, output logic byp);
    logic [33:0] c;
    c   = core_fn(a, b);
    r   = c[31:0];
    un  = c[32];
    ov  = c[33];
    inv = 1'b0;
    byp = 1'b0;
`ifdef FP_SPECIAL_BYPASS_EN
    begin
      bit za, zb, ia, ib, na, nb;
      za = (a[30:23] == 8'h00);
      zb = (b[30:23] == 8'h00);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      if (za || zb || ia || ib || na || nb) begin
        byp = 1'b1;
        ov  = 1'b0;
        un  = 1'b0;
        if (na || nb) r = 32'h7FC0_0000;
        else if ((ia && zb) || (za && ib)) begin
          r   = 32'h7FC0_0000;
          inv = 1'b1;
        end else if (ia || ib) r = {a[31] ^ b[31], 8'hFF, 23'd0};
        else r = {a[31] ^ b[31], 31'd0};
      end
    end
`endif
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Entered at a negedge with in_ready high; returns at a negedge after the output handshake.
  // With chain set, in_valid stays high presenting (na, nb) so the next op follows immediately.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       input bit chain, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] er;
    logic        eo, eu, ei, byp, pre_rst;
    int          n;
    ref_model(a, b, er, eo, eu, ei, byp);
    pre_rst  = mul_RST;
    in_valid = 1'b1;
    A_in     = a;
    B_in     = b;
    @(negedge CLK);
    if (chain) begin
      A_in = na;
      B_in = nb;
    end else begin
      in_valid = 1'b0;
      A_in     = $urandom();
      B_in     = $urandom();
    end
    n = 0;
    while (!out_valid && n < OpLimit) begin
      check_eq("busy_in_ready", 32'(in_ready), 32'd0);
      if (n == 0) check_eq("load_mul_rst", 32'(mul_RST), 32'd0);
      if (n == 1) check_eq("run_mul_rst", 32'(mul_RST), 32'd1);
      out_ready = (n == 2);
      @(negedge CLK);
      n++;
    end
    out_ready = 1'b0;
    // Edges after the accept edge: bypass is visible right after it.
    check_eq("latency", 32'(n), byp ? 32'd0 : 32'(MulCycles + 2));
    check_eq("result", result, er);
    check_eq("overflow", 32'(overflow), 32'(eo));
    check_eq("underflow", 32'(underflow), 32'(eu));
    check_eq("invalid", 32'(invalid), 32'(ei));
    if (byp) begin
      check_eq("byp_mul_rst", 32'(mul_RST), 32'(pre_rst));
    end else begin
      check_eq("mul_A", mul_A, a);
      check_eq("mul_B", mul_B, b);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_result", result, er);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int          k;
    v = $urandom();
    k = $urandom_range(0, 9);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:0] = {8'hFF, 23'd0};
    else if (k == 2) v[30:23] = 8'hFF;
    else v[30:23] = 8'($urandom_range(64, 190));
    return v;
  endfunction

  initial begin
    logic [31:0] ops_a[$];
    logic [31:0] ops_b[$];
    bit          seen;

    RST       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A_in      = 32'd0;
    B_in      = 32'd0;
    repeat (3) @(negedge CLK);
    check_eq("rst_mul_rst", 32'(mul_RST), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    check_eq("rel_mul_rst", 32'(mul_RST), 32'd0);
    check_eq("rel_mul_A", mul_A, 32'd0);
    check_eq("rel_flags", {29'd0, overflow, underflow, invalid}, 32'd0);

    do_op(32'h4000_0000, 32'h4040_0000, 0, 1'b0, 32'd0, 32'd0);
    check_eq("t1_value", result, 32'h40C0_0000);
    do_op(32'hBFC0_0000, 32'h4000_0000, 10, 1'b0, 32'd0, 32'd0);
    check_eq("t2_value", result, 32'hC040_0000);
    do_op(32'h7F80_0000, 32'h0000_0000, 2, 1'b0, 32'd0, 32'd0);
    do_op(32'hFF80_0000, 32'h4000_0000, 1, 1'b0, 32'd0, 32'd0);
    do_op(32'h7F00_0000, 32'h7F00_0000, 1, 1'b1, 32'h3F80_0000, 32'h4000_0000);
    check_eq("t6_overflow", 32'(overflow), 32'd1);
    do_op(32'h3F80_0000, 32'h4000_0000, 0, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of RUN with the iteration count at 10.
    in_valid = 1'b1;
    A_in     = 32'h4000_0000;
    B_in     = 32'h4040_0000;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (11) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_mul_rst", 32'(mul_RST), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("mid_rel_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen |= out_valid;
    end
    check_eq("mid_no_valid", 32'(seen), 32'd0);

    for (int i = 0; i < 25; i++) begin
      ops_a.push_back(rand_operand());
      ops_b.push_back(rand_operand());
    end
    for (int i = 0; i < 24; i++) begin
      do_op(ops_a[i], ops_b[i], $urandom_range(0, 3), (i < 23) && ($urandom_range(0, 1) == 1),
            ops_a[i+1], ops_b[i+1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
